mfp_ahb_uart_tx: RTL and testbench

- AHB-Lite slave UART transmitter for the MIPSfpga system; the transmit counterpart to the serial-load receive path on `UART_RX`.
- Software on the core writes bytes into a transmit FIFO over AHB-Lite. A baud-rate shifter drives them out on `UART_TX` as 8N1 frames, LSB first.
- Sits beside the other GPIO/memory slaves behind the AHB-Lite decoder. Zero wait states, always-OKAY response.

---
 rtl/mfp_ahb_uart_tx_pkg.sv | 33 +++
 rtl/mfp_uart_tx_fifo.sv | 52 +++++
 rtl/mfp_ahb_uart_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_mfp_ahb_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared constants for the MIPSfpga AHB-Lite UART transmitter: register
// offsets (HADDR[3:2]), STATUS bit positions and small helpers.
// Optional feature macro: MFP_UART_TX_PARITY_EN (adds an even-parity bit).
package mfp_ahb_uart_tx_pkg;

   localparam logic [1:0] MFP_UART_TX_DATA_OFF   = 2'd0;
   localparam logic [1:0] MFP_UART_TX_STATUS_OFF = 2'd1;
   localparam logic [1:0] MFP_UART_TX_DIV_OFF    = 2'd2;

   localparam int MFP_UART_TX_ST_FULL    = 0;
   localparam int MFP_UART_TX_ST_EMPTY   = 1;
   localparam int MFP_UART_TX_ST_BUSY    = 2;
   localparam int MFP_UART_TX_ST_OVF     = 3;
   localparam int MFP_UART_TX_ST_PAR     = 4;
   localparam int MFP_UART_TX_ST_CNT_LSB = 8;

`ifdef MFP_UART_TX_PARITY_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   // Even parity over one data byte.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   // FIFO occupancy squeezed into the 8-bit STATUS field.
   function automatic logic [7:0] sat_count8(input logic [31:0] c);
      return (c > 32'd255) ? 8'hFF : c[7:0];
   endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path. Pointers carry one extra
// wrap bit so full and empty are distinguishable. A push while full is
// accepted only when a pop happens in the same cycle.
module mfp_uart_tx_fifo
   import mfp_ahb_uart_tx_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
   assign count     = wr_ptr_r - rd_ptr_r;
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

   // Advance read/write pointers; reset flushes the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Storage array, written on accepted pushes.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite UART transmitter slave: TXDATA/STATUS/DIVISOR registers, a
// transmit FIFO and an 8N1 shifter (LSB first, idle high). Consecutive
// frames are sent without an idle gap.
// Optional feature macro: MFP_UART_TX_PARITY_EN (even parity bit after DATA).
module mfp_ahb_uart_tx
   import mfp_ahb_uart_tx_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
   input  logic        HCLK,
   input  logic        SI_Reset,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic        UART_TX,
   output logic        TX_IRQ
);
`ifdef MFP_UART_TX_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2,
                             ST_STOP = 3'd3, ST_PARITY = 3'd4} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2,
                             ST_STOP = 3'd3} state_t;
`endif

   state_t      state_r, state_n;
   logic [15:0] cnt_r, cnt_n;
   logic [15:0] bdiv_r, bdiv_n;
   logic [7:0]  shift_r, shift_n;
   logic [2:0]  bit_r, bit_n;
   logic        par_r, par_n;
   logic        tx_r, tx_n;
   logic        pop_s;

   logic        dp_sel_r, dp_write_r;
   logic [1:0]  dp_addr_r;
   logic [15:0] div_r;
   logic        ovf_r;
   logic        wr_s, push_s;
   logic [31:0] status_s;

   logic [7:0]  fifo_data_s;
   logic        fifo_full_s, fifo_empty_s;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_s;

   logic        unused_s;
   assign unused_s = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

   assign wr_s      = dp_sel_r & dp_write_r;
   assign push_s    = wr_s & (dp_addr_r == MFP_UART_TX_DATA_OFF);
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign UART_TX   = tx_r;
   assign TX_IRQ    = fifo_empty_s & (state_r == ST_IDLE);

   mfp_uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk       (HCLK),
      .rst       (SI_Reset),
      .push      (push_s),
      .push_data (HWDATA[7:0]),
      .pop       (pop_s),
      .pop_data  (fifo_data_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Register the accepted address phase for the following data phase.
   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         dp_sel_r   <= 1'b0;
         dp_write_r <= 1'b0;
         dp_addr_r  <= 2'd0;
      end else if (HREADY) begin
         dp_sel_r   <= HSEL & HTRANS[1];
         dp_write_r <= HWRITE;
         dp_addr_r  <= HADDR[3:2];
      end
   end

   // DIVISOR register (zero is stored as one) and sticky overflow flag.
   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         div_r <= DIV_DEFAULT;
         ovf_r <= 1'b0;
      end else begin
         if (wr_s && dp_addr_r == MFP_UART_TX_DIV_OFF)
            div_r <= (HWDATA[15:0] == 16'd0) ? 16'd1 : HWDATA[15:0];
         if (push_s && fifo_full_s && !pop_s)
            ovf_r <= 1'b1;
         else if (wr_s && dp_addr_r == MFP_UART_TX_STATUS_OFF && HWDATA[3])
            ovf_r <= 1'b0;
      end
   end

   // Assemble the STATUS word from live FIFO/shifter state.
   always_comb begin
      status_s = 32'd0;
      status_s[MFP_UART_TX_ST_FULL]  = fifo_full_s;
      status_s[MFP_UART_TX_ST_EMPTY] = fifo_empty_s;
      status_s[MFP_UART_TX_ST_BUSY]  = ~TX_IRQ;
      status_s[MFP_UART_TX_ST_OVF]   = ovf_r;
      status_s[MFP_UART_TX_ST_PAR]   = PARITY_EN;
      status_s[MFP_UART_TX_ST_CNT_LSB +: 8] = sat_count8(32'(fifo_count_s));
   end

   // Read mux, driven only during a selected read data phase.
   always_comb begin
      HRDATA = 32'd0;
      if (dp_sel_r && !dp_write_r) begin
         case (dp_addr_r)
            MFP_UART_TX_STATUS_OFF: HRDATA = status_s;
            MFP_UART_TX_DIV_OFF:    HRDATA = {16'd0, div_r};
            default:                HRDATA = 32'd0;
         endcase
      end else begin
         HRDATA = 32'd0;
      end
   end

   // Shifter next-state: each bit is held for bdiv cycles, frames chain on pop.
   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      bdiv_n  = bdiv_r;
      shift_n = shift_r;
      bit_n   = bit_r;
      par_n   = par_r;
      tx_n    = tx_r;
      pop_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               state_n = ST_START;
               tx_n    = 1'b0;
               shift_n = fifo_data_s;
               par_n   = even_parity(fifo_data_s);
               bdiv_n  = div_r;
               cnt_n   = div_r - 16'd1;
            end else begin
               tx_n = 1'b1;
            end
         end
         ST_START: begin
            if (cnt_r == 16'd0) begin
               state_n = ST_DATA;
               cnt_n   = bdiv_r - 16'd1;
               tx_n    = shift_r[0];
               bit_n   = 3'd0;
            end else begin
               cnt_n = cnt_r - 16'd1;
            end
         end
         ST_DATA: begin
            if (cnt_r == 16'd0) begin
               cnt_n = bdiv_r - 16'd1;
               if (bit_r == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                  state_n = ST_PARITY;
                  tx_n    = par_r;
`else
                  state_n = ST_STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  shift_n = shift_r >> 1;
                  tx_n    = shift_r[1];
                  bit_n   = bit_r + 3'd1;
               end
            end else begin
               cnt_n = cnt_r - 16'd1;
            end
         end
`ifdef MFP_UART_TX_PARITY_EN
         ST_PARITY: begin
            if (cnt_r == 16'd0) begin
               state_n = ST_STOP;
               cnt_n   = bdiv_r - 16'd1;
               tx_n    = 1'b1;
            end else begin
               cnt_n = cnt_r - 16'd1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_r == 16'd0) begin
               if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  state_n = ST_START;
                  tx_n    = 1'b0;
                  shift_n = fifo_data_s;
                  par_n   = even_parity(fifo_data_s);
                  bdiv_n  = div_r;
                  cnt_n   = div_r - 16'd1;
               end else begin
                  state_n = ST_IDLE;
                  tx_n    = 1'b1;
               end
            end else begin
               cnt_n = cnt_r - 16'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

   // Shifter state register; reset abandons any frame and idles the line.
   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
         bdiv_r  <= 16'd1;
         shift_r <= 8'd0;
         bit_r   <= 3'd0;
         par_r   <= 1'b0;
         tx_r    <= 1'b1;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         bdiv_r  <= bdiv_n;
         shift_r <= shift_n;
         bit_r   <= bit_n;
         par_r   <= par_n;
         tx_r    <= tx_n;
      end
   end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Self-checking bench for mfp_ahb_uart_tx: bytes are queued as they are
// written and a serial monitor pops and checks each frame bit by bit.
module tb_mfp_ahb_uart_tx;
   localparam int DEPTH = 16;
   localparam logic [1:0] R_DATA = 2'd0;
   localparam logic [1:0] R_STAT = 2'd1;
   localparam logic [1:0] R_DIV  = 2'd2;
`ifdef MFP_UART_TX_PARITY_EN
   localparam int FB = 11;
   localparam logic [31:0] PAR_FLAG = 32'h0000_0010;
`else
   localparam int FB = 10;
   localparam logic [31:0] PAR_FLAG = 32'h0000_0000;
`endif

   logic        HCLK = 1'b0;
   logic        SI_Reset, HSEL, HWRITE, HREADY;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [31:0] HRDATA;
   logic        HREADYOUT, HRESP, UART_TX, TX_IRQ;

   int err_cnt = 0;
   int chk_cnt = 0;
   int cyc = 0;
   int model_div = 434;
   logic [7:0] sb_q[$];

   bit         mon_active = 1'b0;
   bit         b2b_chk = 1'b0;
   logic [10:0] mon_bits;
   logic [7:0] mon_byte;
   int mon_bi, mon_ci, mon_div;
   int last_end_cyc = 0;
   logic [31:0] rd;

   mfp_ahb_uart_tx dut (
      .HCLK(HCLK), .SI_Reset(SI_Reset), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
      .HRESP(HRESP), .UART_TX(UART_TX), .TX_IRQ(TX_IRQ)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Serial monitor: on each start bit, pop the next expected byte and check
   // every cycle of the frame against the bit width in force at the pop.
   always @(negedge HCLK) begin
      if (SI_Reset === 1'b1) begin
         mon_active = 1'b0;
         sb_q.delete();
      end else begin
         if (!mon_active && UART_TX === 1'b0) begin
            chk("start_has_data", 32'(sb_q.size() != 0), 32'd1);
            if (b2b_chk) chk("no_gap", cyc, last_end_cyc + 1);
            mon_byte = 8'h00;
            if (sb_q.size() != 0) mon_byte = sb_q.pop_front();
            mon_bits = '1;
            mon_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) mon_bits[i+1] = mon_byte[i];
`ifdef MFP_UART_TX_PARITY_EN
            mon_bits[9] = ^mon_byte;
`endif
            mon_div = model_div;
            mon_bi = 0;
            mon_ci = 0;
            mon_active = 1'b1;
         end
         if (mon_active) begin
            chk("tx_bit", 32'(UART_TX), 32'(mon_bits[mon_bi]));
            mon_ci++;
            if (mon_ci == mon_div) begin
               mon_ci = 0;
               mon_bi++;
               if (mon_bi == FB) begin
                  mon_active = 1'b0;
                  last_end_cyc = cyc;
               end
            end
         end
      end
   end

   // Back-to-back pipelined writes of first, first+1, ... to one register.
   task automatic ahb_wr(input logic [1:0] idx, input logic [31:0] first, input int n);
      for (int i = 0; i <= n; i++) begin
         HSEL   = (i < n);
         HTRANS = (i < n) ? 2'b10 : 2'b00;
         HWRITE = 1'b1;
         HADDR  = {28'd0, idx, 2'b00};
         HWDATA = (i > 0) ? first + 32'(i - 1) : 32'd0;
         @(posedge HCLK); #1;
      end
   endtask

   task automatic ahb_rd(input logic [1:0] idx, output logic [31:0] d);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b0;
      HADDR  = {28'd0, idx, 2'b00};
      @(posedge HCLK); #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      d = HRDATA;
      @(posedge HCLK); #1;
   endtask

   task automatic wait_idle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge HCLK); #1;
         if (sb_q.size() == 0 && !mon_active && TX_IRQ === 1'b1) done = 1'b1;
      end
      chk("idle_reached", 32'(done), 32'd1);
   endtask

   // One byte from an idle shifter at the current divisor: start falls two
   // cycles after the data phase, IRQ returns after FB bit times.
   task automatic send_one(input logic [7:0] b);
      sb_q.push_back(b);
      ahb_wr(R_DATA, {24'd0, b}, 1);
      chk("irq_fall", 32'(TX_IRQ), 32'd0);
      chk("tx_idle_n1", 32'(UART_TX), 32'd1);
      @(posedge HCLK); #1;
      chk("tx_start_n2", 32'(UART_TX), 32'd0);
      repeat (FB * model_div - 1) @(posedge HCLK);
      #1;
      chk("irq_low_last_stop", 32'(TX_IRQ), 32'd0);
      @(posedge HCLK); #1;
      chk("irq_rise", 32'(TX_IRQ), 32'd1);
   endtask

   initial begin
      SI_Reset = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      HADDR = 32'd0; HSIZE = 3'b010; HWDATA = 32'd0; HREADY = 1'b1;
      repeat (2) @(posedge HCLK);
      #1 SI_Reset = 1'b0;

      // Reset state
      chk("rst_tx", 32'(UART_TX), 32'd1);
      chk("rst_irq", 32'(TX_IRQ), 32'd1);
      chk("rst_hrdata", HRDATA, 32'd0);
      chk("rst_readyout", {30'd0, HREADYOUT, HRESP}, 32'd2);
      ahb_rd(R_STAT, rd); chk("rst_status", rd, 32'h2 | PAR_FLAG);
      ahb_rd(R_DIV, rd);  chk("rst_div", rd, 32'd434);

      // Single frames at DIV=4
      ahb_wr(R_DIV, 32'd4, 1); model_div = 4;
      send_one(8'h55);
      send_one(8'hA5);
`ifdef MFP_UART_TX_PARITY_EN
      send_one(8'h07);
`endif

      // Two bytes: second frame must follow the first stop bit directly
      sb_q.push_back(8'hA1);
      sb_q.push_back(8'hA2);
      ahb_wr(R_DATA, 32'hA1, 2);
      @(posedge HCLK); #1;
      b2b_chk = 1'b1;
      repeat (2 * FB * 4 - 2) @(posedge HCLK);
      #1;
      chk("b2b_irq_low", 32'(TX_IRQ), 32'd0);
      @(posedge HCLK); #1;
      chk("b2b_irq_rise", 32'(TX_IRQ), 32'd1);
      b2b_chk = 1'b0;

      // DIVISOR zero and upper-bit handling
      ahb_wr(R_DIV, 32'd0, 1);
      ahb_rd(R_DIV, rd); chk("div_zero", rd, 32'd1);
      ahb_wr(R_DIV, 32'hFFFF_0005, 1);
      ahb_rd(R_DIV, rd); chk("div_upper", rd, 32'd5);
      ahb_rd(2'd3, rd);  chk("reserved_rd", rd, 32'd0);
      ahb_wr(R_DIV, 32'd4, 1); model_div = 4;

      // DIVISOR change mid-frame only affects the next frame
      sb_q.push_back(8'h3C);
      ahb_wr(R_DATA, 32'h3C, 1);
      repeat (6) @(posedge HCLK);
      #1;
      ahb_wr(R_DIV, 32'd8, 1); model_div = 8;
      wait_idle(200);
      sb_q.push_back(8'hC3);
      ahb_wr(R_DATA, 32'hC3, 1);
      wait_idle(300);
      ahb_rd(R_DIV, rd); chk("div_8", rd, 32'd8);

      // Overflow: first byte goes straight to the shifter, DEPTH fill the
      // FIFO, the last one is dropped
      ahb_wr(R_DIV, 32'd1000, 1); model_div = 1000;
      for (int i = 0; i <= DEPTH; i++) sb_q.push_back(8'h30 + 8'(i));
      ahb_wr(R_DATA, 32'h30, DEPTH + 2);
      ahb_rd(R_STAT, rd);
      chk("ovf_status", rd, 32'h0000_100D | PAR_FLAG);
      ahb_wr(R_STAT, 32'h8, 1);
      ahb_rd(R_STAT, rd);
      chk("ovf_clear", rd, 32'h0000_1005 | PAR_FLAG);
      ahb_wr(R_DIV, 32'd4, 1); model_div = 4;
      wait_idle(20000);
      repeat (30) @(posedge HCLK);
      #1;
      ahb_rd(R_STAT, rd); chk("drain_status", rd, 32'h2 | PAR_FLAG);

      // Reset in the middle of the DATA bits
      sb_q.push_back(8'h5A);
      ahb_wr(R_DATA, 32'h5A, 1);
      repeat (8) @(posedge HCLK);
      #1 SI_Reset = 1'b1;
      @(posedge HCLK); #1;
      SI_Reset = 1'b0;
      chk("midrst_tx", 32'(UART_TX), 32'd1);
      chk("midrst_irq", 32'(TX_IRQ), 32'd1);
      model_div = 434;
      ahb_rd(R_STAT, rd); chk("midrst_status", rd, 32'h2 | PAR_FLAG);
      ahb_rd(R_DIV, rd);  chk("midrst_div", rd, 32'd434);
      repeat (40) @(posedge HCLK);
      #1;
      chk("midrst_line_idle", 32'(UART_TX), 32'd1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
